// File: rtl/ibex_fetch_bus_arbiter.sv
// ibex_fetch_bus_arbiter
// Two fetch requesters share one in-order instruction-memory port (req/gnt/rvalid).
// Port 0 is the prefetch buffer and port 1 is a secondary fetch source.
// The arbiter does three things:
//   - It picks a requester round-robin.
//   - It stays locked on that requester until its request is granted.
//   - It keeps a small owner-ID FIFO so that each in-order response goes back to
//     the requester that issued it.
module ibex_fetch_bus_arbiter #(
    parameter int unsigned MaxOutstanding       = 2,
    // Stray responses (rvalid with nothing outstanding) are tolerated by the logic;
    // this controls whether they are also flagged as a protocol error.
    parameter bit          AssertRvalidNotEmpty = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        m0_req_i,
    input  logic [31:0] m0_addr_i,
    output logic        m0_gnt_o,
    output logic        m0_rvalid_o,

    input  logic        m1_req_i,
    input  logic [31:0] m1_addr_i,
    output logic        m1_gnt_o,
    output logic        m1_rvalid_o,

    output logic [31:0] rdata_o,
    output logic        err_o,

    output logic        bus_req_o,
    output logic [31:0] bus_addr_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_err_i,

    output logic        busy_o
);

    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam logic [CntW-1:0] CntMax  = CntW'(MaxOutstanding);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);

    // Lock state: IDLE arbitrates freely, LOCKED holds the bus on lock_id_reg
    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]                state_reg, state_next;
    logic                      lock_id_reg, lock_id_next;
    logic                      rr_ptr_reg, rr_ptr_next;
    logic [CntW-1:0]           count_reg, count_next;
    logic [PtrW-1:0]           wr_ptr_reg, wr_ptr_next;
    logic [PtrW-1:0]           rd_ptr_reg, rd_ptr_next;
    logic [MaxOutstanding-1:0] owner_reg, owner_next;

    logic sel;
    logic full;
    logic empty;
    logic grant;
    logic push;
    logic pop;
    logic head;

    // Only word addresses reach the bus; the byte-offset bits are discarded
    logic unused_addr_bits;
    assign unused_addr_bits = ^{m0_addr_i[1:0], m1_addr_i[1:0]};

    // Advance a FIFO pointer, wrapping at MaxOutstanding (not a power of two in general)
    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrLast) begin
            return '0;
        end
        return p + PtrW'(1);
    endfunction

    assign full  = (count_reg == CntMax);
    assign empty = (count_reg == '0);

    // Requester selection: lock wins, then a lone requester, then round-robin
    always_comb begin
        sel = 1'b0;
        if (state_reg == ST_LOCKED) begin
            sel = lock_id_reg;
        end else if (m0_req_i && !m1_req_i) begin
            sel = 1'b0;
        end else if (!m0_req_i && m1_req_i) begin
            sel = 1'b1;
        end else if (m0_req_i && m1_req_i) begin
            sel = rr_ptr_reg;
        end
    end

    // When the owner FIFO is full, requests are held off. A response arriving in
    // the same cycle does not refill the slot until the next cycle.
    assign bus_req_o  = ~full & ((state_reg == ST_LOCKED) | m0_req_i | m1_req_i);
    assign bus_addr_o = {(sel ? m1_addr_i[31:2] : m0_addr_i[31:2]), 2'b00};

    assign grant    = bus_req_o & bus_gnt_i;
    assign m0_gnt_o = grant & ~sel;
    assign m1_gnt_o = grant & sel;

    // Responses come back in order, so the FIFO head always names their owner
    assign push        = grant;
    assign pop         = bus_rvalid_i & ~empty;
    assign head        = owner_reg[rd_ptr_reg];
    assign m0_rvalid_o = pop & ~head;
    assign m1_rvalid_o = pop & head;

    assign rdata_o = bus_rdata_i;
    assign err_o   = bus_err_i;
    assign busy_o  = bus_req_o | ~empty;

    // Lock and round-robin bookkeeping
    always_comb begin
        state_next   = state_reg;
        lock_id_next = lock_id_reg;
        rr_ptr_next  = rr_ptr_reg;
        if (bus_req_o && !bus_gnt_i) begin
            state_next   = ST_LOCKED;
            lock_id_next = sel;
        end else if (grant) begin
            state_next = ST_IDLE;
        end
        if (grant) begin
            rr_ptr_next = ~sel;
        end
    end

    // Owner FIFO pointers and occupancy; a simultaneous push and pop leave the count unchanged
    always_comb begin
        wr_ptr_next = push ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
        rd_ptr_next = pop  ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
        count_next  = count_reg;
        if (push && !pop) begin
            count_next = count_reg + CntW'(1);
        end else if (!push && pop) begin
            count_next = count_reg - CntW'(1);
        end
    end

    // Owner storage: each slot captures the granted requester ID when written
    for (genvar gi = 0; gi < MaxOutstanding; gi++) begin : g_owner
        assign owner_next[gi] = (push && (wr_ptr_reg == PtrW'(gi))) ? sel : owner_reg[gi];
    end

    // State registers. Resetting clears the FIFO, so responses to requests
    // issued before the reset are later dropped as strays.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_reg   <= ST_IDLE;
            lock_id_reg <= 1'b0;
            rr_ptr_reg  <= 1'b0;
            count_reg   <= '0;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            owner_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            lock_id_reg <= lock_id_next;
            rr_ptr_reg  <= rr_ptr_next;
            count_reg   <= count_next;
            wr_ptr_reg  <= wr_ptr_next;
            rd_ptr_reg  <= rd_ptr_next;
            owner_reg   <= owner_next;
        end
    end

    // Protocol checks:
    //   - A requester must keep its request and address stable until it is granted.
    //   - The occupancy count must never exceed MaxOutstanding.
    a_m0_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (m0_req_i && !m0_gnt_o) |=> (m0_req_i && $stable(m0_addr_i)));
    a_m1_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (m1_req_i && !m1_gnt_o) |=> (m1_req_i && $stable(m1_addr_i)));
    a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
        count_reg <= CntMax);

    if (AssertRvalidNotEmpty) begin : g_rvalid_check
        // A response with nothing outstanding indicates a bus-side protocol error
        a_rvalid_not_empty: assert property (@(posedge clk_i) disable iff (!rst_ni)
            bus_rvalid_i |-> !empty);
    end

endmodule

// File: tb/tb_ibex_fetch_bus_arbiter.sv
// Directed, table-driven bench for ibex_fetch_bus_arbiter (MaxOutstanding = 2)
module tb_ibex_fetch_bus_arbiter;

    localparam logic [31:0] A0 = 32'h0000_0080;
    localparam logic [31:0] A1 = 32'h0000_0107;
    localparam logic [31:0] A1_BUS = 32'h0000_0104;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        m0_req_i, m1_req_i;
    logic [31:0] m0_addr_i, m1_addr_i;
    logic        m0_gnt_o, m0_rvalid_o, m1_gnt_o, m1_rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        bus_req_o;
    logic [31:0] bus_addr_o;
    logic        bus_gnt_i, bus_rvalid_i, bus_err_i;
    logic [31:0] bus_rdata_i;
    logic        busy_o;

    int checks = 0;
    int failures = 0;

    always #5 clk_i = ~clk_i;

    ibex_fetch_bus_arbiter #(
        .MaxOutstanding       (2),
        .AssertRvalidNotEmpty (1'b0)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .m0_req_i     (m0_req_i),
        .m0_addr_i    (m0_addr_i),
        .m0_gnt_o     (m0_gnt_o),
        .m0_rvalid_o  (m0_rvalid_o),
        .m1_req_i     (m1_req_i),
        .m1_addr_i    (m1_addr_i),
        .m1_gnt_o     (m1_gnt_o),
        .m1_rvalid_o  (m1_rvalid_o),
        .rdata_o      (rdata_o),
        .err_o        (err_o),
        .bus_req_o    (bus_req_o),
        .bus_addr_o   (bus_addr_o),
        .bus_gnt_i    (bus_gnt_i),
        .bus_rvalid_i (bus_rvalid_i),
        .bus_rdata_i  (bus_rdata_i),
        .bus_err_i    (bus_err_i),
        .busy_o       (busy_o)
    );

    // ctrl bit order: {bus_req, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, busy, err}
    typedef struct {
        logic        rst_n;
        logic        m0r;
        logic        m1r;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        err;
        logic [6:0]  exp_ctrl;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst_n, input logic m0r, input logic m1r, input logic gnt,
                       input logic rv, input logic [31:0] rdata, input logic err,
                       input logic [6:0] ctrl, input logic [31:0] addr);
        vec_t v;
        v.rst_n = rst_n; v.m0r = m0r; v.m1r = m1r; v.gnt = gnt; v.rv = rv;
        v.rdata = rdata; v.err = err; v.exp_ctrl = ctrl; v.exp_addr = addr;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic logic [6:0] ctrl_now();
        return {bus_req_o, m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o, busy_o, err_o};
    endfunction

    // Drive one cycle of inputs on the falling edge, then let outputs settle
    task automatic drive(input logic rst_n, input logic m0r, input logic m1r, input logic gnt,
                         input logic rv, input logic [31:0] rdata, input logic err);
        @(negedge clk_i);
        rst_ni = rst_n; m0_req_i = m0r; m1_req_i = m1r; bus_gnt_i = gnt;
        bus_rvalid_i = rv; bus_rdata_i = rdata; bus_err_i = err;
        #2;
    endtask

    initial begin
        //   rst m0 m1 gnt rv  rdata          err  ctrl        addr
        add(1, 0, 0, 0, 0, 32'h0,          0, 7'b0000000, A0);     // 0  post-reset idle
        add(1, 1, 0, 1, 0, 32'h0,          0, 7'b1100010, A0);     // 1  m0 granted
        add(1, 0, 0, 0, 1, 32'hDEADBEEF,   0, 7'b0001010, A0);     // 2  m0 response
        add(1, 0, 0, 0, 0, 32'h0,          0, 7'b0000000, A0);     // 3  idle
        add(1, 0, 1, 1, 0, 32'h0,          0, 7'b1010010, A1_BUS); // 4  m1 granted, addr[1:0] cleared
        add(1, 0, 0, 0, 1, 32'h11111111,   0, 7'b0000110, A0);     // 5  m1 response
        add(1, 1, 1, 1, 0, 32'h0,          0, 7'b1100010, A0);     // 6  both: rr -> m0
        add(1, 1, 1, 1, 1, 32'h22222222,   0, 7'b1011010, A1_BUS); // 7  m1 gnt + m0 rvalid, count=1
        add(1, 1, 1, 1, 1, 32'h33333333,   0, 7'b1100110, A0);     // 8  m0 gnt + m1 rvalid
        add(1, 1, 1, 1, 1, 32'h44444444,   0, 7'b1011010, A1_BUS); // 9  m1 gnt + m0 rvalid
        add(1, 1, 0, 1, 1, 32'h55555555,   0, 7'b1100110, A0);     // 10 m0 gnt + m1 rvalid
        add(1, 0, 1, 0, 1, 32'h66666666,   0, 7'b1001010, A1_BUS); // 11 m1 stalled -> lock, m0 rvalid
        add(1, 1, 1, 0, 0, 32'h0,          0, 7'b1000010, A1_BUS); // 12 locked on m1
        add(1, 1, 1, 0, 0, 32'h0,          0, 7'b1000010, A1_BUS); // 13 locked on m1
        add(1, 1, 1, 1, 0, 32'h0,          0, 7'b1010010, A1_BUS); // 14 m1 granted on 4th cycle
        add(1, 1, 0, 1, 0, 32'h0,          0, 7'b1100010, A0);     // 15 m0 next -> full
        add(1, 1, 1, 1, 0, 32'h0,          0, 7'b0000010, A0);     // 16 full: no req
        add(1, 1, 1, 1, 1, 32'h77777777,   0, 7'b0000110, A0);     // 17 full + rvalid: still no req
        add(1, 1, 1, 1, 0, 32'h0,          0, 7'b1010010, A1_BUS); // 18 req reasserted, rr -> m1
        add(1, 1, 0, 1, 1, 32'h88888888,   0, 7'b0001010, A0);     // 19 full again + rvalid m0
        add(1, 1, 0, 1, 1, 32'h99999999,   1, 7'b1100111, A0);     // 20 m0 gnt + m1 rvalid with err
        add(1, 0, 0, 0, 1, 32'hAAAAAAAA,   0, 7'b0001010, A0);     // 21 m0 rvalid
        add(1, 0, 0, 0, 0, 32'h0,          0, 7'b0000000, A0);     // 22 idle
        add(1, 0, 1, 1, 0, 32'h0,          0, 7'b1010010, A1_BUS); // 23 m1 granted
        add(1, 1, 0, 1, 0, 32'h0,          0, 7'b1100010, A0);     // 24 m0 granted, 2 outstanding
        add(0, 0, 0, 0, 0, 32'h0,          0, 7'b0000010, A0);     // 25 reset with 2 outstanding
        add(1, 0, 0, 0, 1, 32'hBBBBBBBB,   0, 7'b0000000, A0);     // 26 stale response dropped
        add(1, 0, 0, 0, 1, 32'hCCCCCCCC,   0, 7'b0000000, A0);     // 27 stale response dropped
        add(1, 1, 1, 1, 0, 32'h0,          0, 7'b1100010, A0);     // 28 rr reset -> m0 first
        add(1, 0, 1, 1, 1, 32'hDDDDDDDD,   0, 7'b1011010, A1_BUS); // 29 m1 gnt + m0 rvalid
        add(1, 0, 0, 0, 1, 32'hEEEEEEEE,   0, 7'b0000110, A0);     // 30 m1 rvalid
        add(1, 0, 0, 0, 0, 32'h0,          0, 7'b0000000, A0);     // 31 idle

        m0_addr_i = A0;
        m1_addr_i = A1;
        rst_ni = 1'b0; m0_req_i = 1'b0; m1_req_i = 1'b0; bus_gnt_i = 1'b0;
        bus_rvalid_i = 1'b0; bus_rdata_i = '0; bus_err_i = 1'b0;
        repeat (2) @(posedge clk_i);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst_n, vecs[i].m0r, vecs[i].m1r, vecs[i].gnt,
                  vecs[i].rv, vecs[i].rdata, vecs[i].err);
            $display("vec %0d: ctrl=%b bus_addr=%h rdata=%h", i, ctrl_now(), bus_addr_o, rdata_o);
            check($sformatf("vec%0d_ctrl", i), 64'(ctrl_now()), 64'(vecs[i].exp_ctrl));
            check($sformatf("vec%0d_rdata", i), 64'(rdata_o), 64'(vecs[i].rdata));
            if (vecs[i].exp_ctrl[6]) begin
                check($sformatf("vec%0d_addr", i), 64'(bus_addr_o), 64'(vecs[i].exp_addr));
            end
        end

        // Hand sequence: lock on m1 while m0 (the round-robin favourite) also requests
        drive(1, 0, 1, 0, 0, 32'h0, 0);
        $display("seq lock start: ctrl=%b bus_addr=%h", ctrl_now(), bus_addr_o);
        check("seq_lock_start", {31'h0, ctrl_now(), bus_addr_o}, {31'h0, 7'b1000010, A1_BUS});
        for (int c = 0; c < 3; c++) begin
            drive(1, 1, 1, 0, 0, 32'h0, 0);
            $display("seq lock hold %0d: ctrl=%b bus_addr=%h", c, ctrl_now(), bus_addr_o);
            check($sformatf("seq_lock_hold%0d", c), {31'h0, ctrl_now(), bus_addr_o},
                  {31'h0, 7'b1000010, A1_BUS});
        end
        drive(1, 1, 1, 1, 0, 32'h0, 0);
        $display("seq lock grant: ctrl=%b", ctrl_now());
        check("seq_lock_grant", 64'(ctrl_now()), 64'(7'b1010010));

        // Bounded wait for m0's grant once m1 has been served
        begin
            int waited;
            waited = 0;
            drive(1, 1, 0, 1, 0, 32'h0, 0);
            while (!m0_gnt_o && waited < 4) begin
                drive(1, 1, 0, 1, 0, 32'h0, 0);
                waited++;
            end
            $display("seq m0 grant: m0_gnt=%b waited=%0d", m0_gnt_o, waited);
            check("seq_m0_grant", {63'(waited), m0_gnt_o}, {63'd0, 1'b1});
        end

        // Responses return in grant order: m1 first, then m0
        drive(1, 0, 0, 0, 1, 32'h12345678, 0);
        $display("seq rsp 0: ctrl=%b rdata=%h", ctrl_now(), rdata_o);
        check("seq_rsp0", 64'(ctrl_now()), 64'(7'b0000110));
        drive(1, 0, 0, 0, 1, 32'h9ABCDEF0, 0);
        $display("seq rsp 1: ctrl=%b rdata=%h", ctrl_now(), rdata_o);
        check("seq_rsp1", 64'(ctrl_now()), 64'(7'b0001010));
        drive(1, 0, 0, 0, 0, 32'h0, 0);
        $display("seq idle: ctrl=%b", ctrl_now());
        check("seq_idle", 64'(ctrl_now()), 64'(7'b0000000));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
